npc_core_mc: RTL and testbench

//  Parametrised multi-cycle NPC core: fetch/decode/execute FSM with integrated register file.

---
 rtl/npc_pkg.sv | 21 ++
 rtl/npc_regfile.sv | 31 +++
 rtl/npc_core_mc.sv | 113 +++++++++++
 tb/tb_npc_core_mc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared opcodes, FSM states and immediate sign-extension helpers for the NPC core
package npc_pkg;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [6:0] F7_ADD  = 7'b0000000;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  typedef enum logic [2:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT, S_TRAP} state_t;
  function automatic logic [63:0] sext_i(input logic [31:0] i);
    return {{52{i[31]}}, i[31:20]};
  endfunction
  function automatic logic [63:0] sext_u(input logic [31:0] i);
    return {{32{i[31]}}, i[31:12], 12'b0};
  endfunction
  function automatic logic [63:0] sext_j(input logic [31:0] i);
    return {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/npc_regfile.sv
// npc_regfile: two combinational read ports, one write port, x0 hardwired to zero
module npc_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  input  logic [4:0]      i_rd,
  input  logic            i_we,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rs1,
  output logic [XLEN-1:0] o_rs2
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0] NR = 6'(NREG);
  logic [XLEN-1:0] r_regs [NREG];
  logic w_ok1, w_ok2, w_okd;
  // out-of-range indices read as zero so the array is never over-indexed
  assign w_ok1 = (i_rs1 != 5'd0) && ({1'b0, i_rs1} < NR);
  assign w_ok2 = (i_rs2 != 5'd0) && ({1'b0, i_rs2} < NR);
  assign w_okd = (i_rd != 5'd0) && ({1'b0, i_rd} < NR);
  assign o_rs1 = w_ok1 ? r_regs[i_rs1[AW-1:0]] : '0;
  assign o_rs2 = w_ok2 ? r_regs[i_rs2[AW-1:0]] : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    else if (i_we && w_okd)
      r_regs[i_rd[AW-1:0]] <= i_wdata;
endmodule

// File: rtl/npc_core_mc.sv
// npc_core_mc: multi-cycle fetch/wait/exec RV core for ADDI, ADD, LUI, JAL, JALR, EBREAK
module npc_core_mc
  import npc_pkg::*;
#(
  parameter int          XLEN     = 64,
  parameter int          NREG     = 32,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic [XLEN-1:0] npc_data,
  output logic            halted,
  output logic            trap
);
  localparam logic [5:0] NR = 6'(NREG);
  state_t          r_state;
  logic [XLEN-1:0] r_pc, r_npc;
  logic [31:0]     r_inst;
  logic            r_retire, r_halted, r_trap;
  logic [6:0]      w_op, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [63:0]     w_ii, w_iu, w_ij;
  logic [XLEN-1:0] w_rs1v, w_rs2v, w_target, w_pc4, w_result, w_wdata;
  logic            w_addi, w_add, w_lui, w_jal, w_jalr, w_ebreak, w_jump;
  logic            w_use_rs1, w_use_rs2, w_use_rd, w_bad_reg, w_legal, w_we;
  assign w_op  = r_inst[6:0];
  assign w_rd  = r_inst[11:7];
  assign w_f3  = r_inst[14:12];
  assign w_rs1 = r_inst[19:15];
  assign w_rs2 = r_inst[24:20];
  assign w_f7  = r_inst[31:25];
  assign w_ii  = sext_i(r_inst);
  assign w_iu  = sext_u(r_inst);
  assign w_ij  = sext_j(r_inst);
  assign w_addi   = (w_op == OP_IMM) && (w_f3 == F3_ADD);
  assign w_add    = (w_op == OP_REG) && (w_f3 == F3_ADD) && (w_f7 == F7_ADD);
  assign w_lui    = (w_op == OP_LUI);
  assign w_jal    = (w_op == OP_JAL);
  assign w_jalr   = (w_op == OP_JALR) && (w_f3 == F3_ADD);
  assign w_ebreak = (r_inst == INST_EBREAK);
  assign w_jump   = w_jal | w_jalr;
  assign w_use_rs1 = w_addi | w_add | w_jalr;
  assign w_use_rs2 = w_add;
  assign w_use_rd  = w_addi | w_add | w_lui | w_jal | w_jalr;
  // only register fields the instruction actually uses can make it illegal
  assign w_bad_reg = (w_use_rd && ({1'b0, w_rd} >= NR)) | (w_use_rs1 && ({1'b0, w_rs1} >= NR)) |
                     (w_use_rs2 && ({1'b0, w_rs2} >= NR));
  assign w_pc4    = r_pc + XLEN'(4);
  assign w_target = w_jal ? r_pc + w_ij[XLEN-1:0] : (w_rs1v + w_ii[XLEN-1:0]) & ~XLEN'(1);
  assign w_legal  = w_use_rd && !w_bad_reg && !(w_jump && w_target[1]);
  assign w_result = w_addi ? w_rs1v + w_ii[XLEN-1:0] :
                    w_add  ? w_rs1v + w_rs2v :
                    w_lui  ? w_iu[XLEN-1:0] : w_pc4;
  assign w_wdata  = (w_rd == 5'd0) ? '0 : w_result;
  assign w_we     = (r_state == S_EXEC) && w_legal;
  npc_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk(clk), .rst(rst),
    .i_rs1(w_rs1), .i_rs2(w_rs2), .i_rd(w_rd),
    .i_we(w_we), .i_wdata(w_result),
    .o_rs1(w_rs1v), .o_rs2(w_rs2v)
  );
  assign imem_req_valid = rst && (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign retire    = r_retire;
  assign npc_data  = r_npc;
  assign halted    = r_halted;
  assign trap      = r_trap;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC[XLEN-1:0];
      r_inst   <= '0;
      r_npc    <= '0;
      r_retire <= 1'b0;
      r_halted <= 1'b0;
      r_trap   <= 1'b0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH: if (imem_req_ready) r_state <= S_WAIT;
        S_WAIT:
          if (imem_resp_valid) begin
            r_inst  <= imem_rdata;
            r_state <= S_EXEC;
          end
        S_EXEC:
          if (w_ebreak) begin
            r_retire <= 1'b1;
            r_halted <= 1'b1;
            r_npc    <= '0;
            r_state  <= S_HALT;
          end else if (!w_legal) begin
            r_trap  <= 1'b1;
            r_state <= S_TRAP;
          end else begin
            r_retire <= 1'b1;
            r_npc    <= w_wdata;
            r_pc     <= w_jump ? w_target : w_pc4;
            r_state  <= S_FETCH;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_npc_core_mc.sv
// tb_npc_core_mc: directed and random instruction checks against an ISA-level reference model
module tb_npc_core_mc;
  localparam logic [63:0] RPC = 64'h8000_0000;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst32, rst16, ready, resp_valid, sel16;
  logic [31:0] rdata;
  logic v32, ret32, h32, t32, v16, ret16, h16, t16;
  logic [63:0] a32, pc32, nd32, a16, pc16, nd16;
  logic sv, sret, sh, st;
  logic [63:0] sa, spc, snd;
  int checks = 0, errors = 0;
  logic [63:0] m_regs [32];
  logic [63:0] m_pc;
  int m_nreg;
  npc_core_mc #(.XLEN(64), .NREG(32), .RESET_PC(RPC)) u32 (
    .clk(clk), .rst(rst32), .imem_req_valid(v32), .imem_req_ready(ready), .imem_addr(a32),
    .imem_resp_valid(resp_valid), .imem_rdata(rdata), .pc(pc32), .retire(ret32),
    .npc_data(nd32), .halted(h32), .trap(t32)
  );
  npc_core_mc #(.XLEN(64), .NREG(16), .RESET_PC(RPC)) u16 (
    .clk(clk), .rst(rst16), .imem_req_valid(v16), .imem_req_ready(ready), .imem_addr(a16),
    .imem_resp_valid(resp_valid), .imem_rdata(rdata), .pc(pc16), .retire(ret16),
    .npc_data(nd16), .halted(h16), .trap(t16)
  );
  assign sv   = sel16 ? v16 : v32;
  assign sa   = sel16 ? a16 : a32;
  assign spc  = sel16 ? pc16 : pc32;
  assign sret = sel16 ? ret16 : ret32;
  assign snd  = sel16 ? nd16 : nd32;
  assign sh   = sel16 ? h16 : h32;
  assign st   = sel16 ? t16 : t32;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut();
    ready = 1'b0;
    resp_valid = 1'b0;
    if (sel16) rst16 = 1'b0; else rst32 = 1'b0;
    #1;
    chk("rst_req_valid", sv, 0);
    tick();
    tick();
    if (sel16) rst16 = 1'b1; else rst32 = 1'b1;
    #1;
    m_nreg = sel16 ? 16 : 32;
    m_pc = RPC;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    chk("rel_valid", sv, 1);
    chk("rel_addr", sa, RPC);
    chk("rel_pc", spc, RPC);
    chk("rel_out", {sret, sh, st}, 0);
    chk("rel_npc", snd, 0);
  endtask
  // kind: 0 retired, 1 halted, 2 trapped
  task automatic model_exec(input logic [31:0] in, output int kind, output logic [63:0] nd);
    int rd, rs1, rs2;
    longint ii, ji, ui;
    logic [63:0] a, b, res, tgt;
    bit jump, u1, u2;
    rd = int'(in[11:7]);
    rs1 = int'(in[19:15]);
    rs2 = int'(in[24:20]);
    ii = $signed(in) >>> 20;
    ji = $signed({in[31], in[19:12], in[20], in[30:21], 1'b0, 11'b0}) >>> 11;
    ui = $signed({in[31:12], 12'h000});
    a = (rs1 < m_nreg) ? m_regs[rs1] : 64'd0;
    b = (rs2 < m_nreg) ? m_regs[rs2] : 64'd0;
    kind = 2;
    nd = '0;
    jump = 0;
    u1 = 0;
    u2 = 0;
    res = '0;
    tgt = m_pc + 64'd4;
    if (in == 32'h0010_0073) begin
      kind = 1;
      return;
    end
    if (in[6:0] == 7'h13 && in[14:12] == 3'd0) begin res = a + ii; u1 = 1; end
    else if (in[6:0] == 7'h33 && in[14:12] == 3'd0 && in[31:25] == 7'd0) begin res = a + b; u1 = 1; u2 = 1; end
    else if (in[6:0] == 7'h37) res = ui;
    else if (in[6:0] == 7'h6F) begin res = m_pc + 64'd4; tgt = m_pc + ji; jump = 1; end
    else if (in[6:0] == 7'h67 && in[14:12] == 3'd0) begin
      res = m_pc + 64'd4; tgt = (a + ii) & ~64'd1; jump = 1; u1 = 1;
    end else return;
    if (rd >= m_nreg || (u1 && rs1 >= m_nreg) || (u2 && rs2 >= m_nreg)) return;
    if (jump && tgt[1]) return;
    kind = 0;
    nd = (rd == 0) ? 64'd0 : res;
    if (rd != 0) m_regs[rd] = res;
    m_pc = tgt;
  endtask
  task automatic run_inst(input logic [31:0] inst, input int rdly, input int wdly, output int kind);
    logic [63:0] nd, old_pc;
    old_pc = m_pc;
    chk("fetch_valid", sv, 1);
    chk("fetch_addr", sa, m_pc);
    for (int i = 0; i < rdly; i++) begin
      ready = 1'b0;
      resp_valid = (i == 0);
      rdata = 32'h0010_0073;
      tick();
      resp_valid = 1'b0;
      chk("stall_valid", sv, 1);
      chk("stall_addr", sa, old_pc);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("wait_valid", sv, 0);
    for (int i = 0; i < wdly; i++) tick();
    resp_valid = 1'b1;
    rdata = inst;
    tick();
    resp_valid = 1'b0;
    rdata = '0;
    chk("exec_retire", sret, 0);
    model_exec(inst, kind, nd);
    tick();
    if (kind == 0) begin
      chk("ret_pulse", sret, 1);
      chk("ret_npc", snd, nd);
      chk("ret_pc", spc, m_pc);
      chk("ret_trap", st, 0);
    end else if (kind == 1) begin
      chk("halt_pulse", sret, 1);
      chk("halt_flag", sh, 1);
      chk("halt_pc", spc, old_pc);
      tick();
      chk("halt_noret", sret, 0);
      chk("halt_noreq", sv, 0);
    end else begin
      chk("trap_flag", st, 1);
      chk("trap_noret", sret, 0);
      chk("trap_pc", spc, old_pc);
      tick();
      chk("trap_noreq", sv, 0);
    end
  endtask
  function automatic logic [31:0] gen();
    logic [4:0] rd, rs1, rs2;
    logic [11:0] i12;
    logic [19:0] u20;
    logic [20:0] off;
    int r;
    r = $urandom_range(0, 99);
    rd = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    i12 = 12'($urandom);
    u20 = 20'($urandom);
    off = 21'($urandom) & 21'h1FFFFC;
    off[1] = ($urandom_range(0, 3) == 0);
    if (r < 30) return {i12, rs1, 3'b000, rd, 7'h13};
    if (r < 50) return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
    if (r < 62) return {u20, rd, 7'h37};
    if (r < 77) return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
    if (r < 92) return {i12, rs1, 3'b000, rd, 7'h67};
    return $urandom;
  endfunction
  initial begin
    int kind;
    sel16 = 1'b0;
    rst32 = 1'b0;
    rst16 = 1'b0;
    ready = 1'b0;
    resp_valid = 1'b0;
    rdata = '0;
    m_nreg = 32;
    reset_dut();
    run_inst(32'h0050_0093, 0, 0, kind);
    chk("addi_npc", snd, 64'd5);
    run_inst(32'h0010_80B3, 3, 1, kind);
    chk("add_npc", snd, 64'd10);
    chk("add_pc", spc, 64'h8000_0008);
    reset_dut();
    run_inst(32'h0080_00EF, 0, 0, kind);
    chk("jal_npc", snd, 64'h8000_0004);
    chk("jal_addr", sa, 64'h8000_0008);
    run_inst(32'h0010_0073, 0, 0, kind);
    tick();
    chk("halt_sticky", sh, 1);
    chk("halt_idle", sv, 0);
    reset_dut();
    run_inst(32'h0000_0000, 1, 0, kind);
    chk("illegal_kind", kind, 2);
    rst32 = 1'b0;
    sel16 = 1'b1;
    reset_dut();
    run_inst(32'h0050_0893, 0, 0, kind);
    chk("rve_trap", st, 1);
    reset_dut();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("abort_wait", sv, 0);
    rst16 = 1'b0;
    resp_valid = 1'b1;
    rdata = 32'h0050_0093;
    tick();
    rst16 = 1'b1;
    #1;
    chk("abort_refetch", sv, 1);
    chk("abort_addr", sa, RPC);
    tick();
    resp_valid = 1'b0;
    chk("abort_noret", sret, 0);
    chk("abort_pc", spc, RPC);
    m_pc = RPC;
    run_inst(32'h0050_0093, 0, 0, kind);
    rst16 = 1'b0;
    sel16 = 1'b0;
    reset_dut();
    for (int n = 0; n < 250; n++) begin
      run_inst(gen(), $urandom_range(0, 2), $urandom_range(0, 2), kind);
      if (kind != 0) reset_dut();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
